// File: rtl/rf_tx_arbiter.sv
// ============================================================================
// rf_tx_arbiter
// ----------------------------------------------------------------------------
// Shares the single RF/DAC transmit sample port between the BLE PHY and the
// WiFi PHY transmit paths, one packet at a time.
//
// Each requester is granted for a whole packet. Its samples are handed over
// through a one-entry registered output stage. A fixed inter-frame gap is
// inserted after every packet, and a stalled packet is aborted with a
// zero-valued closing sample.
//
// Optional build macro:
//   RF_ARB_STATS_EN : adds the saturating statistics outputs ble_pkt_cnt,
//                     wifi_pkt_cnt and abort_cnt. When the macro is not
//                     defined, these ports and their registers do not exist.
//
// Ports:
//   HCLK, HRESET       system clock, asynchronous active-high reset
//   ble_*  / wifi_*    per-PHY req/valid/re/im/last inputs and ready output
//   prio_wifi          1 = WiFi has fixed priority, 0 = round robin
//   out_ready          downstream can accept a sample
//   out_valid/re/im/last/src
//                      registered shared output (src: 0 = BLE, 1 = WiFi)
//   busy               high whenever the arbiter is not IDLE
//   abort_pulse        one-cycle pulse when a stalled packet is aborted
// ============================================================================
module rf_tx_arbiter #(
    parameter int RE_IM_SIZE     = 12,
    parameter int GAP_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  HCLK,
    input  logic                  HRESET,

    input  logic                  ble_req,
    input  logic                  ble_valid,
    input  logic [RE_IM_SIZE-1:0] ble_re,
    input  logic [RE_IM_SIZE-1:0] ble_im,
    input  logic                  ble_last,
    output logic                  ble_ready,

    input  logic                  wifi_req,
    input  logic                  wifi_valid,
    input  logic [RE_IM_SIZE-1:0] wifi_re,
    input  logic [RE_IM_SIZE-1:0] wifi_im,
    input  logic                  wifi_last,
    output logic                  wifi_ready,

    input  logic                  prio_wifi,
    input  logic                  out_ready,

    output logic                  out_valid,
    output logic [RE_IM_SIZE-1:0] out_re,
    output logic [RE_IM_SIZE-1:0] out_im,
    output logic                  out_last,
    output logic                  out_src,
    output logic                  busy,
    output logic                  abort_pulse
`ifdef RF_ARB_STATS_EN
    ,
    output logic [15:0]           ble_pkt_cnt,
    output logic [15:0]           wifi_pkt_cnt,
    output logic [7:0]            abort_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_GRANT_BLE  = 2'd1,
        ST_GRANT_WIFI = 2'd2,
        ST_GAP        = 2'd3
    } state_t;

    localparam logic SRC_BLE  = 1'b0;
    localparam logic SRC_WIFI = 1'b1;

    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    // Terminal counts: the counters run 0 .. N-1, so the N-th counted cycle
    // is the one that sees the terminal value.
    localparam logic [GAP_W-1:0] GAP_END = GAP_W'(GAP_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_END  = TO_W'(TIMEOUT_CYCLES - 1);

    state_t                  state_q, state_d;
    logic                    last_served_q, last_served_d;
    logic [GAP_W-1:0]        gap_cnt_q, gap_cnt_d;
    logic [TO_W-1:0]         to_cnt_q, to_cnt_d;
    logic                    out_valid_q, out_valid_d;
    logic                    out_last_q, out_last_d;
    logic                    out_src_q, out_src_d;
    logic [RE_IM_SIZE-1:0]   out_re_q, out_re_d;
    logic [RE_IM_SIZE-1:0]   out_im_q, out_im_d;
    logic                    abort_q, abort_d;

    // Granted-side view of the two requesters.
    logic                    grant_wifi;
    logic                    in_grant;
    logic                    g_valid;
    logic                    g_last;
    logic [RE_IM_SIZE-1:0]   g_re;
    logic [RE_IM_SIZE-1:0]   g_im;
    logic                    out_space;
    logic                    xfer;
    logic                    pkt_done;
    logic                    timeout_hit;

    always_comb begin : grant_mux
        grant_wifi  = (state_q == ST_GRANT_WIFI);
        in_grant    = grant_wifi || (state_q == ST_GRANT_BLE);
        g_valid     = grant_wifi ? wifi_valid : ble_valid;
        g_last      = grant_wifi ? wifi_last  : ble_last;
        g_re        = grant_wifi ? wifi_re    : ble_re;
        g_im        = grant_wifi ? wifi_im    : ble_im;
        // One-entry output stage: a slot is free when it is empty or being
        // drained on this edge.
        out_space   = out_ready || !out_valid_q;
        xfer        = in_grant && g_valid && out_space;
        pkt_done    = xfer && g_last;
        // The closing sample of an abort needs a free output slot, so
        // downstream backpressure holds the counter at its terminal value.
        timeout_hit = in_grant && !g_valid && out_space && (to_cnt_q == TO_END);
        ble_ready   = (state_q == ST_GRANT_BLE) && out_space;
        wifi_ready  = grant_wifi && out_space;
    end

    always_comb begin : next_state
        // NOTE: every variable gets a default before the case statement so
        // that no path leaves it unassigned and no latch is inferred.
        state_d       = state_q;
        last_served_d = last_served_q;
        gap_cnt_d     = gap_cnt_q;
        to_cnt_d      = to_cnt_q;
        out_valid_d   = out_valid_q;
        out_last_d    = out_last_q;
        out_src_d     = out_src_q;
        out_re_d      = out_re_q;
        out_im_d      = out_im_q;
        abort_d       = 1'b0;

        // Downstream accepted the held sample; a load below may refill it.
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end

        unique case (state_q)
            ST_IDLE: begin
                gap_cnt_d = '0;
                to_cnt_d  = '0;
                // WiFi wins on priority, when alone, or when BLE was served
                // last; otherwise BLE wins if it is requesting.
                if (wifi_req && (prio_wifi || !ble_req || last_served_q == SRC_BLE)) begin
                    state_d = ST_GRANT_WIFI;
                end else if (ble_req) begin
                    state_d = ST_GRANT_BLE;
                end
            end

            ST_GRANT_BLE, ST_GRANT_WIFI: begin
                if (xfer) begin
                    out_valid_d = 1'b1;
                    out_last_d  = g_last;
                    out_re_d    = g_re;
                    out_im_d    = g_im;
                    out_src_d   = grant_wifi;
                    to_cnt_d    = '0;
                    if (g_last) begin
                        state_d       = ST_GAP;
                        last_served_d = grant_wifi;
                    end
                end else if (timeout_hit) begin
                    // Close the frame downstream with a zero last sample.
                    out_valid_d   = 1'b1;
                    out_last_d    = 1'b1;
                    out_re_d      = '0;
                    out_im_d      = '0;
                    out_src_d     = grant_wifi;
                    abort_d       = 1'b1;
                    to_cnt_d      = '0;
                    state_d       = ST_GAP;
                    last_served_d = grant_wifi;
                end else if (!g_valid && (to_cnt_q != TO_END)) begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end

            ST_GAP: begin
                // The gap is measured from the moment the last sample has
                // left the output register.
                if (out_valid_q) begin
                    gap_cnt_d = '0;
                end else if (gap_cnt_q == GAP_END) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples its _d value from before the edge, independent of order.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q       <= ST_IDLE;
            last_served_q <= SRC_WIFI;
            gap_cnt_q     <= '0;
            to_cnt_q      <= '0;
            out_valid_q   <= 1'b0;
            out_last_q    <= 1'b0;
            out_src_q     <= 1'b0;
            out_re_q      <= '0;
            out_im_q      <= '0;
            abort_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_served_q <= last_served_d;
            gap_cnt_q     <= gap_cnt_d;
            to_cnt_q      <= to_cnt_d;
            out_valid_q   <= out_valid_d;
            out_last_q    <= out_last_d;
            out_src_q     <= out_src_d;
            out_re_q      <= out_re_d;
            out_im_q      <= out_im_d;
            abort_q       <= abort_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_last    = out_last_q;
    assign out_src     = out_src_q;
    assign out_re      = out_re_q;
    assign out_im      = out_im_q;
    assign abort_pulse = abort_q;
    assign busy        = (state_q != ST_IDLE);

`ifdef RF_ARB_STATS_EN
    logic [15:0] ble_pkt_cnt_q, ble_pkt_cnt_d;
    logic [15:0] wifi_pkt_cnt_q, wifi_pkt_cnt_d;
    logic [7:0]  abort_cnt_q, abort_cnt_d;

    // Saturating statistics: completed packets per source and aborts.
    always_comb begin : stats_next
        ble_pkt_cnt_d  = ble_pkt_cnt_q;
        wifi_pkt_cnt_d = wifi_pkt_cnt_q;
        abort_cnt_d    = abort_cnt_q;
        if (pkt_done && !grant_wifi && (ble_pkt_cnt_q != 16'hFFFF)) begin
            ble_pkt_cnt_d = ble_pkt_cnt_q + 16'd1;
        end
        if (pkt_done && grant_wifi && (wifi_pkt_cnt_q != 16'hFFFF)) begin
            wifi_pkt_cnt_d = wifi_pkt_cnt_q + 16'd1;
        end
        if (abort_d && (abort_cnt_q != 8'hFF)) begin
            abort_cnt_d = abort_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            ble_pkt_cnt_q  <= '0;
            wifi_pkt_cnt_q <= '0;
            abort_cnt_q    <= '0;
        end else begin
            ble_pkt_cnt_q  <= ble_pkt_cnt_d;
            wifi_pkt_cnt_q <= wifi_pkt_cnt_d;
            abort_cnt_q    <= abort_cnt_d;
        end
    end

    assign ble_pkt_cnt  = ble_pkt_cnt_q;
    assign wifi_pkt_cnt = wifi_pkt_cnt_q;
    assign abort_cnt    = abort_cnt_q;
`endif

endmodule
